// File: rtl/fx_pkg.sv
// Shared widths, constants and the output sample record for the ADC fuzz stage.
package fx_pkg;

  localparam int CH_W         = 5;
  localparam int DATA_W       = 12;
  localparam int OUT_W        = 16;
  localparam int ADC_MIDSCALE = 2048;
  localparam int GAIN_FRAC    = 4;

  // Record layout pushed through the output FIFO: {data, clipped}.
  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic                    clipped;
  } fx_sample_t;

endpackage

// File: rtl/fx_skid_fifo.sv
// Two-entry FIFO with 1-bit wrapping pointers; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module fx_skid_fifo #(
  parameter int REC_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [REC_W-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [REC_W-1:0] pop_data,
  output logic             empty
);

  logic [REC_W-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against current occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != 2'd0);
    do_push_s = push && ((count_r != 2'd2) || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  assign full     = (count_r == 2'd2);
  assign empty    = (count_r == 2'd0);
  assign pop_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/adc_fuzz_stage.sv
// ADC response post-processing: centre, Q4.4 gain and symmetric clip, then a
// 2-entry output FIFO; results arriving at a full FIFO are counted as drops.
module adc_fuzz_stage #(
  parameter int CH_W   = fx_pkg::CH_W,
  parameter int DATA_W = fx_pkg::DATA_W,
  parameter int OUT_W  = fx_pkg::OUT_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              adc_response_valid,
  input  logic [CH_W-1:0]   adc_response_channel,
  input  logic [DATA_W-1:0] adc_response_data,
  input  logic [CH_W-1:0]   cfg_channel,
  input  logic [7:0]        cfg_gain,
  input  logic [14:0]       cfg_clip,
  input  logic              cfg_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_clipped,
  output logic [15:0]       drop_count
);
  import fx_pkg::*;

  localparam int C_W   = DATA_W + 1;
  localparam int P_W   = DATA_W + 9;
  localparam int G_W   = P_W - GAIN_FRAC;
  localparam int REC_W = OUT_W + 1;

  logic                  accept_s;
  logic signed [C_W-1:0] centre_s;
  logic signed [P_W-1:0] prod_s;
  logic signed [G_W-1:0] gain_s;
  logic signed [G_W-1:0] clip_s;
  logic signed [G_W-1:0] neg_clip_s;
  logic signed [G_W-1:0] res_s;
  logic                  res_clipped_s;

  logic                  s1_valid_r, s2_valid_r, s3_valid_r;
  logic signed [C_W-1:0] s1_c_r, s2_c_r;
  logic [7:0]            s1_gain_r;
  logic [14:0]           s1_clip_r, s2_clip_r;
  logic                  s1_bypass_r, s2_bypass_r;
  logic signed [G_W-1:0] s2_g_r;
  logic [REC_W-1:0]      s3_rec_r;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [REC_W-1:0]      fifo_head_s;
  logic                  pop_s;
  logic                  drop_s;

  // Datapath arithmetic for all three stages.
  always_comb begin
    accept_s   = adc_response_valid && (adc_response_channel == cfg_channel);
    centre_s   = $signed({1'b0, adc_response_data} - C_W'(ADC_MIDSCALE));
    prod_s     = $signed({{(P_W-C_W){s1_c_r[C_W-1]}}, s1_c_r}) *
                 $signed({{(P_W-8){1'b0}}, s1_gain_r});
    gain_s     = G_W'(prod_s >>> GAIN_FRAC);
    clip_s     = $signed({{(G_W-15){1'b0}}, s2_clip_r});
    neg_clip_s = -clip_s;
    if (s2_bypass_r) begin
      res_s         = {{(G_W-C_W){s2_c_r[C_W-1]}}, s2_c_r};
      res_clipped_s = 1'b0;
    end else if (s2_g_r > clip_s) begin
      res_s         = clip_s;
      res_clipped_s = 1'b1;
    end else if (s2_g_r < neg_clip_s) begin
      res_s         = neg_clip_s;
      res_clipped_s = 1'b1;
    end else begin
      res_s         = s2_g_r;
      res_clipped_s = 1'b0;
    end
  end

  // Pipeline registers; config is snapshotted with each accepted beat.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_valid_r  <= 1'b0;
      s2_valid_r  <= 1'b0;
      s3_valid_r  <= 1'b0;
      s1_c_r      <= '0;
      s2_c_r      <= '0;
      s1_gain_r   <= 8'd0;
      s1_clip_r   <= 15'd0;
      s2_clip_r   <= 15'd0;
      s1_bypass_r <= 1'b0;
      s2_bypass_r <= 1'b0;
      s2_g_r      <= '0;
      s3_rec_r    <= '0;
    end else begin
      s1_valid_r  <= accept_s;
      s1_c_r      <= centre_s;
      s1_gain_r   <= cfg_gain;
      s1_clip_r   <= cfg_clip;
      s1_bypass_r <= cfg_bypass;
      s2_valid_r  <= s1_valid_r;
      s2_c_r      <= s1_c_r;
      s2_g_r      <= gain_s;
      s2_clip_r   <= s1_clip_r;
      s2_bypass_r <= s1_bypass_r;
      s3_valid_r  <= s2_valid_r;
      s3_rec_r    <= {OUT_W'(res_s), res_clipped_s};
    end
  end

  assign pop_s  = !fifo_empty_s && out_ready;
  assign drop_s = s3_valid_r && fifo_full_s && !pop_s;

  fx_skid_fifo #(
    .REC_W (REC_W)
  ) u_fifo (
    .clk       (clk_clk),
    .reset     (reset_reset),
    .push      (s3_valid_r),
    .push_data (s3_rec_r),
    .full      (fifo_full_s),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .empty     (fifo_empty_s)
  );

  // Saturating drop counter.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      drop_count <= 16'd0;
    end else if (drop_s && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end else begin
      drop_count <= drop_count;
    end
  end

  assign out_valid   = !fifo_empty_s;
  assign out_data    = fifo_head_s[REC_W-1:1];
  assign out_clipped = fifo_head_s[0];

endmodule

// File: tb/tb_adc_fuzz_stage.sv
// Directed self-checking bench for adc_fuzz_stage.
module tb_adc_fuzz_stage;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        adc_response_valid;
  logic [4:0]  adc_response_channel;
  logic [11:0] adc_response_data;
  logic [4:0]  cfg_channel;
  logic [7:0]  cfg_gain;
  logic [14:0] cfg_clip;
  logic        cfg_bypass;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_clipped;
  logic [15:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_clk = ~clk_clk;

  adc_fuzz_stage dut (
    .clk_clk              (clk_clk),
    .reset_reset          (reset_reset),
    .adc_response_valid   (adc_response_valid),
    .adc_response_channel (adc_response_channel),
    .adc_response_data    (adc_response_data),
    .cfg_channel          (cfg_channel),
    .cfg_gain             (cfg_gain),
    .cfg_clip             (cfg_clip),
    .cfg_bypass           (cfg_bypass),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_clipped          (out_clipped),
    .drop_count           (drop_count)
  );

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_clip"}, 32'(out_clipped), 32'(c));
  endtask

  initial begin
    reset_reset          = 1'b1;
    adc_response_valid   = 1'b0;
    adc_response_channel = 5'd2;
    adc_response_data    = 12'h000;
    cfg_channel          = 5'd2;
    cfg_gain             = 8'h10;
    cfg_clip             = 15'h7FFF;
    cfg_bypass           = 1'b0;
    out_ready            = 1'b1;
    tick();
    tick();
    reset_reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_clip", 32'(out_clipped), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // Unity gain, latency 3
    adc_response_valid = 1'b1;
    adc_response_data  = 12'hC00;
    tick();
    adc_response_valid = 1'b0;
    chk("lat_n1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_n2", 32'(out_valid), 32'd0);
    tick();
    chk("lat_n3", 32'(out_valid), 32'd0);
    tick();
    chk_out("unity", 16'h0400, 1'b0);
    tick();
    chk("unity_drain", 32'(out_valid), 32'd0);

    // Config snapshot: gain 2.0 captured, then config changed in flight
    cfg_gain           = 8'h20;
    adc_response_valid = 1'b1;
    adc_response_data  = 12'h810;
    tick();
    adc_response_valid = 1'b0;
    cfg_gain   = 8'h10;
    cfg_clip   = 15'd0;
    cfg_bypass = 1'b1;
    tick();
    tick();
    tick();
    chk_out("snap", 16'h0020, 1'b0);
    tick();

    // Gain 8.0 with clip at +/-10000
    cfg_bypass         = 1'b0;
    cfg_gain           = 8'h80;
    cfg_clip           = 15'd10000;
    adc_response_valid = 1'b1;
    adc_response_data  = 12'hFFF;
    tick();
    adc_response_data  = 12'h000;
    tick();
    adc_response_valid = 1'b0;
    tick();
    tick();
    chk_out("clip_pos", 16'h2710, 1'b1);
    tick();
    chk_out("clip_neg", 16'hD8F0, 1'b1);
    tick();
    chk("clip_drain", 32'(out_valid), 32'd0);

    // Bypass with max gain
    cfg_bypass         = 1'b1;
    cfg_gain           = 8'hFF;
    adc_response_valid = 1'b1;
    adc_response_data  = 12'h800;
    tick();
    adc_response_data  = 12'h7FF;
    tick();
    adc_response_valid = 1'b0;
    tick();
    tick();
    chk_out("byp_zero", 16'h0000, 1'b0);
    tick();
    chk_out("byp_m1", 16'hFFFF, 1'b0);
    tick();

    // Non-matching channel is ignored
    cfg_bypass           = 1'b0;
    cfg_gain             = 8'h10;
    cfg_clip             = 15'h7FFF;
    cfg_channel          = 5'd1;
    adc_response_channel = 5'd3;
    adc_response_valid   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      adc_response_data = 12'(i * 300 + 17);
      if (i == 4) adc_response_valid = 1'b0;
      tick();
      chk("nomatch", 32'(out_valid), 32'd0);
    end
    adc_response_channel = 5'd1;

    // Backpressure: 5 beats, FIFO holds 2, 3 dropped
    out_ready          = 1'b0;
    adc_response_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      adc_response_data = 12'(12'h800 + i);
      tick();
    end
    adc_response_valid = 1'b0;
    chk_out("bp_head", 16'h0001, 1'b0);
    tick();
    tick();
    tick();
    chk_out("bp_hold", 16'h0001, 1'b0);
    chk("bp_drop", 32'(drop_count), 32'd3);
    tick();
    chk("bp_drop_stable", 32'(drop_count), 32'd3);
    out_ready = 1'b1;
    tick();
    chk_out("bp_second", 16'h0002, 1'b0);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Full FIFO with simultaneous pop and push: nothing dropped
    out_ready          = 1'b0;
    adc_response_valid = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      adc_response_data = 12'(12'h800 + i);
      tick();
    end
    adc_response_valid = 1'b0;
    tick();
    tick();
    chk_out("pp_head", 16'h000A, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_out("pp_b", 16'h000B, 1'b0);
    chk("pp_nodrop", 32'(drop_count), 32'd3);
    tick();
    chk_out("pp_c", 16'h000C, 1'b0);
    tick();
    chk("pp_empty", 32'(out_valid), 32'd0);
    chk("pp_drop_final", 32'(drop_count), 32'd3);

    // Reset with FIFO full and a result still in flight
    out_ready          = 1'b0;
    adc_response_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      adc_response_data = 12'(12'h800 + i);
      tick();
    end
    adc_response_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_drop", 32'(drop_count), 32'd3);
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    adc_response_valid = 1'b1;
    adc_response_data  = 12'hC00;
    tick();
    adc_response_valid = 1'b0;
    tick();
    tick();
    chk("resume_n2", 32'(out_valid), 32'd0);
    tick();
    chk_out("resume", 16'h0400, 1'b0);
    chk("resume_drop", 32'(drop_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
